// File: rtl/bsg_transpose_stream.sv
// Streaming square bit-matrix transposer: collects width_p rows, then emits
// the transposed matrix one row per yumi. One matrix in flight at a time.

module bsg_transpose_row #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               we,
  input  logic [width_p-1:0] d,
  output logic [width_p-1:0] q
);
  // Plain storage flops; contents are meaningless until written in FILL.
  always_ff @(posedge clk_i)
    if (we) q <= d;
endmodule

module bsg_transpose_stream #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);
  localparam int cnt_w = $clog2(width_p);
  localparam logic [cnt_w-1:0] last = cnt_w'(width_p - 1);

  typedef enum logic {FILL, DRAIN} state_e;

  state_e                          state_r, state_n;
  logic [cnt_w-1:0]                cnt_r, cnt_n;
  logic                            wr;
  logic [width_p-1:0][width_p-1:0] mem;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= FILL;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // clear_i beats any handshake in the same cycle and suppresses the write.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    wr      = 1'b0;
    if (clear_i) begin
      state_n = FILL;
      cnt_n   = '0;
    end else if (state_r == FILL) begin
      if (v_i) begin
        wr = 1'b1;
        if (cnt_r == last) begin
          cnt_n   = '0;
          state_n = DRAIN;
        end else begin
          cnt_n = cnt_r + 1'b1;
        end
      end
    end else if (yumi_i) begin
      if (cnt_r == last) begin
        cnt_n   = '0;
        state_n = FILL;
      end else begin
        cnt_n = cnt_r + 1'b1;
      end
    end
  end

  assign ready_o = (state_r == FILL);
  assign v_o     = (state_r == DRAIN);

  // Row r owns its storage; output bit r picks column cnt_r of that row.
  for (genvar r = 0; r < width_p; r++) begin : g_row
    bsg_transpose_row #(.width_p(width_p)) u_row (
      .clk_i (clk_i),
      .we    (wr && (cnt_r == cnt_w'(r))),
      .d     (data_i),
      .q     (mem[r])
    );
    assign data_o[r] = mem[r][cnt_r];
  end
endmodule

// File: tb/tb_bsg_transpose_stream.sv
// Directed bench for bsg_transpose_stream at width_p = 16, 2 and 5.
module tb_bsg_transpose_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        clr16 = 1'b0, v16 = 1'b0, y16 = 1'b0;
  logic [15:0] d16 = '0;
  logic        rdy16, vo16;
  logic [15:0] q16;

  logic        v2 = 1'b0, y2 = 1'b0;
  logic [1:0]  d2 = '0;
  logic        rdy2, vo2;
  logic [1:0]  q2;

  logic        v5 = 1'b0, y5 = 1'b0;
  logic [4:0]  d5 = '0;
  logic        rdy5, vo5;
  logic [4:0]  q5;
  logic        clr0 = 1'b0;

  logic [15:0] mat16 [16];
  logic [15:0] exp16;
  logic [4:0]  mat5 [5];
  logic [4:0]  exp5;

  bsg_transpose_stream #(.width_p(16)) u16 (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr16), .data_i(d16), .v_i(v16),
    .ready_o(rdy16), .data_o(q16), .v_o(vo16), .yumi_i(y16));
  bsg_transpose_stream #(.width_p(2)) u2 (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr0), .data_i(d2), .v_i(v2),
    .ready_o(rdy2), .data_o(q2), .v_o(vo2), .yumi_i(y2));
  bsg_transpose_stream #(.width_p(5)) u5 (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr0), .data_i(d5), .v_i(v5),
    .ready_o(rdy5), .data_o(q5), .v_o(vo5), .yumi_i(y5));

  // yumi without v_o is a protocol violation on the bench side.
  always @(posedge clk)
    if (rst_n && ((y16 && !vo16) || (y2 && !vo2) || (y5 && !vo5))) begin
      bad++;
      $display("FAIL illegal_yumi y16=%b vo16=%b y2=%b vo2=%b y5=%b vo5=%b",
               y16, vo16, y2, vo2, y5, vo5);
    end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drive mat16 in back-to-back, no checks.
  task automatic fill16;
    for (int r = 0; r < 16; r++) begin
      d16 = mat16[r];
      v16 = 1'b1;
      step();
    end
    v16 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    total++;
    if (rdy16 !== 1'b1 || vo16 !== 1'b0) begin
      bad++;
      $display("FAIL reset16 got rdy=%b v=%b exp rdy=1 v=0", rdy16, vo16);
    end
    total++;
    if ({rdy2, vo2, rdy5, vo5} !== 4'b1010) begin
      bad++;
      $display("FAIL reset_small got %b exp 1010", {rdy2, vo2, rdy5, vo5});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_identity;
    for (int r = 0; r < 16; r++) begin
      d16 = 16'h0001 << r;
      v16 = 1'b1;
      total++;
      if (rdy16 !== 1'b1 || vo16 !== 1'b0) begin
        bad++;
        $display("FAIL ident_fill r=%0d got rdy=%b v=%b exp 1 0", r, rdy16, vo16);
      end
      step();
    end
    v16 = 1'b0;
    total++;
    if (vo16 !== 1'b1 || rdy16 !== 1'b0) begin
      bad++;
      $display("FAIL ident_latency got v=%b rdy=%b exp 1 0", vo16, rdy16);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (q16 !== (16'h0001 << k)) begin
        bad++;
        $display("FAIL ident_row k=%0d got %h exp %h", k, q16, 16'h0001 << k);
      end
      y16 = 1'b1;
      step();
    end
    y16 = 1'b0;
    total++;
    if (vo16 !== 1'b0 || rdy16 !== 1'b1) begin
      bad++;
      $display("FAIL ident_back_to_fill got v=%b rdy=%b exp 0 1", vo16, rdy16);
    end
  endtask

  task automatic test_single_column;
    for (int r = 0; r < 16; r++) mat16[r] = 16'h0001;
    fill16();
    for (int k = 0; k < 16; k++) begin
      total++;
      if (q16 !== ((k == 0) ? 16'hFFFF : 16'h0000)) begin
        bad++;
        $display("FAIL col0 k=%0d got %h", k, q16);
      end
      y16 = 1'b1;
      step();
    end
    y16 = 1'b0;
    for (int r = 0; r < 16; r++) mat16[r] = (r == 5) ? 16'h8000 : 16'h0000;
    fill16();
    for (int k = 0; k < 16; k++) begin
      total++;
      if (q16 !== ((k == 15) ? 16'h0020 : 16'h0000)) begin
        bad++;
        $display("FAIL col15 k=%0d got %h", k, q16);
      end
      y16 = 1'b1;
      step();
    end
    y16 = 1'b0;
  endtask

  task automatic test_random;
    for (int m = 0; m < 200; m++) begin
      for (int r = 0; r < 16; r++) mat16[r] = 16'($urandom);
      for (int r = 0; r < 16; r++) begin
        while ($urandom_range(0, 3) == 0) begin
          v16 = 1'b0;
          total++;
          if (rdy16 !== 1'b1 || vo16 !== 1'b0) begin
            bad++;
            $display("FAIL rnd_fill_gap m=%0d got rdy=%b v=%b", m, rdy16, vo16);
          end
          step();
        end
        d16 = mat16[r];
        v16 = 1'b1;
        total++;
        if (rdy16 !== 1'b1 || vo16 !== 1'b0) begin
          bad++;
          $display("FAIL rnd_fill m=%0d r=%0d got rdy=%b v=%b", m, r, rdy16, vo16);
        end
        step();
      end
      v16 = 1'b0;
      for (int k = 0; k < 16; k++) begin
        for (int j = 0; j < 16; j++) exp16[j] = mat16[j][k];
        while ($urandom_range(0, 3) == 0) begin
          y16 = 1'b0;
          total++;
          if (q16 !== exp16 || vo16 !== 1'b1 || rdy16 !== 1'b0) begin
            bad++;
            $display("FAIL rnd_stall m=%0d k=%0d got %h v=%b rdy=%b exp %h",
                     m, k, q16, vo16, rdy16, exp16);
          end
          step();
        end
        total++;
        if (q16 !== exp16 || vo16 !== 1'b1 || rdy16 !== 1'b0) begin
          bad++;
          $display("FAIL rnd_row m=%0d k=%0d got %h v=%b rdy=%b exp %h",
                   m, k, q16, vo16, rdy16, exp16);
        end
        y16 = 1'b1;
        step();
        y16 = 1'b0;
      end
    end
  endtask

  task automatic test_clear_fill;
    for (int r = 0; r < 7; r++) begin
      d16 = 16'hFFFF;
      v16 = 1'b1;
      step();
    end
    v16 = 1'b0;
    clr16 = 1'b1;
    step();
    clr16 = 1'b0;
    for (int r = 0; r < 16; r++) mat16[r] = 16'h0001 << (15 - r);
    for (int r = 0; r < 16; r++) begin
      d16 = mat16[r];
      v16 = 1'b1;
      step();
      if (r == 14) begin
        total++;
        if (vo16 !== 1'b0) begin
          bad++;
          $display("FAIL clr7_early_v got v=%b exp 0", vo16);
        end
      end
    end
    v16 = 1'b0;
    total++;
    if (vo16 !== 1'b1) begin
      bad++;
      $display("FAIL clr7_v got v=%b exp 1", vo16);
    end
    // anti-diagonal: output row k = 1 << (15-k)
    for (int k = 0; k < 16; k++) begin
      total++;
      if (q16 !== (16'h0001 << (15 - k))) begin
        bad++;
        $display("FAIL clr7_row k=%0d got %h exp %h", k, q16, 16'h0001 << (15 - k));
      end
      y16 = 1'b1;
      step();
    end
    y16 = 1'b0;
  endtask

  task automatic test_clear_drain;
    for (int r = 0; r < 16; r++) mat16[r] = 16'h1234 ^ 16'(r);
    fill16();
    y16 = 1'b1;
    repeat (3) step();
    y16 = 1'b0;
    clr16 = 1'b1;
    step();
    clr16 = 1'b0;
    total++;
    if (vo16 !== 1'b0 || rdy16 !== 1'b1) begin
      bad++;
      $display("FAIL clr_drain got v=%b rdy=%b exp 0 1", vo16, rdy16);
    end
  endtask

  task automatic test_clear_last;
    // Clear coincident with the 16th accept.
    for (int r = 0; r < 15; r++) begin
      d16 = 16'hFFFF;
      v16 = 1'b1;
      step();
    end
    clr16 = 1'b1;
    step();
    clr16 = 1'b0;
    v16 = 1'b0;
    total++;
    if (vo16 !== 1'b0 || rdy16 !== 1'b1) begin
      bad++;
      $display("FAIL clr_last_accept got v=%b rdy=%b exp 0 1", vo16, rdy16);
    end
    for (int r = 0; r < 16; r++) mat16[r] = 16'h0001 << r;
    fill16();
    y16 = 1'b1;
    repeat (15) step();
    // Clear coincident with the last yumi.
    clr16 = 1'b1;
    step();
    clr16 = 1'b0;
    y16 = 1'b0;
    total++;
    if (vo16 !== 1'b0 || rdy16 !== 1'b1) begin
      bad++;
      $display("FAIL clr_last_yumi got v=%b rdy=%b exp 0 1", vo16, rdy16);
    end
    // cnt_r must be 0: a fresh identity comes out starting at row 0.
    fill16();
    for (int k = 0; k < 16; k++) begin
      total++;
      if (q16 !== (16'h0001 << k)) begin
        bad++;
        $display("FAIL clr_last_after k=%0d got %h exp %h", k, q16, 16'h0001 << k);
      end
      y16 = 1'b1;
      step();
    end
    y16 = 1'b0;
  endtask

  task automatic test_async_reset;
    for (int r = 0; r < 16; r++) mat16[r] = 16'hFFFF;
    fill16();
    y16 = 1'b1;
    repeat (4) step();
    y16 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (vo16 !== 1'b0 || rdy16 !== 1'b1) begin
      bad++;
      $display("FAIL async_rst got v=%b rdy=%b exp 0 1", vo16, rdy16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int r = 0; r < 16; r++) mat16[r] = (r % 2 == 0) ? 16'hAAAA : 16'h5555;
    fill16();
    // odd columns come from even rows (AAAA), even columns from odd rows
    for (int k = 0; k < 16; k++) begin
      total++;
      if (q16 !== ((k % 2 == 1) ? 16'h5555 : 16'hAAAA)) begin
        bad++;
        $display("FAIL async_after k=%0d got %h", k, q16);
      end
      y16 = 1'b1;
      step();
    end
    y16 = 1'b0;
  endtask

  task automatic test_width2;
    d2 = 2'b10; v2 = 1'b1; step();
    d2 = 2'b01; step();
    v2 = 1'b0;
    total++;
    if (vo2 !== 1'b1 || q2 !== 2'b10) begin
      bad++;
      $display("FAIL w2_row0 got v=%b q=%b exp 1 10", vo2, q2);
    end
    y2 = 1'b1; step(); y2 = 1'b0;
    total++;
    if (vo2 !== 1'b1 || q2 !== 2'b01) begin
      bad++;
      $display("FAIL w2_row1 got v=%b q=%b exp 1 01", vo2, q2);
    end
    y2 = 1'b1; step(); y2 = 1'b0;
    total++;
    if (vo2 !== 1'b0 || rdy2 !== 1'b1) begin
      bad++;
      $display("FAIL w2_end got v=%b rdy=%b exp 0 1", vo2, rdy2);
    end
  endtask

  task automatic test_width5;
    for (int m = 0; m < 20; m++) begin
      for (int r = 0; r < 5; r++) mat5[r] = 5'($urandom);
      for (int r = 0; r < 5; r++) begin
        d5 = mat5[r];
        v5 = 1'b1;
        step();
      end
      v5 = 1'b0;
      for (int k = 0; k < 5; k++) begin
        for (int j = 0; j < 5; j++) exp5[j] = mat5[j][k];
        total++;
        if (vo5 !== 1'b1 || q5 !== exp5) begin
          bad++;
          $display("FAIL w5 m=%0d k=%0d got v=%b q=%b exp %b", m, k, vo5, q5, exp5);
        end
        y5 = 1'b1;
        step();
        y5 = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_single_column();
    test_random();
    test_clear_fill();
    test_clear_drain();
    test_clear_last();
    test_async_reset();
    test_width2();
    test_width5();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
